// File: rtl/fp_mult_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pkg
// Purpose  : Shared types and constants for the FP multiplier scheduler.
//            - FP_W     : IEEE-754 single-precision word width
//            - FP_QNAN  : quiet NaN returned when an operation times out
//            - state_t  : scheduler FSM states
//            - fp_is_zero(): true for +0.0 / -0.0 (exponent and mantissa 0)
// Revision : 1.0 - initial release
// ============================================================================
package fp_mult_pkg;

    localparam int               FP_W    = 32;
    localparam logic [FP_W-1:0]  FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Sign bit is deliberately ignored: both signed zeros count as zero.
    function automatic logic fp_is_zero(input logic [FP_W-1:0] w);
        return (w[30:23] == 8'd0) && (w[22:0] == 23'd0);
    endfunction

endpackage : fp_mult_pkg
`default_nettype wire

// File: rtl/fp_mult_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_scheduler_if
// Purpose  : Bundles the requester-side and multiplier-side signals of the
//            FP multiplier scheduler.
//   Requester side : req_valid/req_ready/req_a/req_b, rsp_valid/rsp_ready/
//                    rsp_data/rsp_err
//   Multiplier side: mult_start/mult_a/mult_b, mult_product/mult_done
//   Status         : busy
//   Modports       : slave  - the scheduler
//                    master - the environment (requesters + multiplier)
// Revision : 1.0 - initial release
// ============================================================================
interface fp_mult_scheduler_if #(
    parameter int N_REQ = 4
);
    import fp_mult_pkg::*;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [FP_W*N_REQ-1:0]  req_a;
    logic [FP_W*N_REQ-1:0]  req_b;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [FP_W-1:0]        rsp_data;
    logic                   rsp_err;
    logic                   mult_start;
    logic [FP_W-1:0]        mult_a;
    logic [FP_W-1:0]        mult_b;
    logic [FP_W-1:0]        mult_product;
    logic                   mult_done;
    logic                   busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mult_product, mult_done,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               mult_start, mult_a, mult_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mult_product, mult_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               mult_start, mult_a, mult_b, busy
    );

endinterface : fp_mult_scheduler_if
`default_nettype wire

// File: rtl/fp_mult_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches i_req starting at
//            i_rr_ptr and wrapping; the first set bit wins.
//   i_req        : request vector
//   i_rr_ptr     : index with highest priority this cycle
//   i_en         : grant enable (no grant when low)
//   o_grant      : one-hot grant
//   o_grant_idx  : index of the granted requester
//   o_grant_vld  : a grant is being issued
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [IW-1:0] i_rr_ptr,
    input  wire logic          i_en,
    output logic [N-1:0]       o_grant,
    output logic [IW-1:0]      o_grant_idx,
    output logic               o_grant_vld
);

    logic          w_hit;
    logic [IW-1:0] w_idx;

    // Index of the k-th candidate counted from the pointer, modulo N.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Walk from the lowest priority candidate to the highest so the last
    // hit (the one closest to the pointer) overwrites earlier ones.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[wrap_idx(i_rr_ptr, k)]) begin
                w_hit = 1'b1;
                w_idx = wrap_idx(i_rr_ptr, k);
            end
        end
    end

    always_comb begin
        o_grant          = '0;
        o_grant[w_idx]   = i_en & w_hit;
        o_grant_idx      = w_idx;
        o_grant_vld      = i_en & w_hit;
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fp_mult_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_scheduler
// Purpose  : Shares one single-precision multiplier between N_REQ requesters.
//            Round-robin accept in IDLE, one-cycle start pulse in ISSUE,
//            wait for done (with watchdog) in WAIT, return the result to the
//            owner in RESP. Zero operands get a signed-zero result because
//            the multiplier leaves its product untouched for them.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : scheduler side (slave) of fp_mult_scheduler_if
// Parameters: N_REQ   - number of requesters (2..8)
//             TIMEOUT - WAIT cycles before the op is abandoned (>= 4)
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_scheduler
    import fp_mult_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    fp_mult_scheduler_if.slave   bus
);

    localparam int              IW          = $clog2(N_REQ);
    localparam int              CW          = $clog2(TIMEOUT);
    localparam logic [IW-1:0]   c_PTR_LAST  = IW'(N_REQ - 1);
    localparam logic [CW-1:0]   c_TMO_LAST  = CW'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_owner;
    logic [FP_W-1:0]    r_op_a;
    logic [FP_W-1:0]    r_op_b;
    logic               r_zero_op;
    logic               r_sign;
    logic [CW-1:0]      r_wdog;
    logic [FP_W-1:0]    r_rsp_data;
    logic               r_rsp_err;

    logic [N_REQ-1:0]   w_grant;
    logic [IW-1:0]      w_grant_idx;
    logic               w_grant_vld;
    logic               w_arb_en;
    logic               w_accept;
    logic               w_done_hit;
    logic               w_timeout;
    logic [FP_W-1:0]    w_sel_a;
    logic [FP_W-1:0]    w_sel_b;
    logic [N_REQ-1:0]   w_rsp_valid;

    // ------------------------------------------------------------------
    // Arbitration: only in IDLE, and never while reset is asserted so
    // req_ready reads 0 during reset regardless of req_valid.
    // ------------------------------------------------------------------
    assign w_arb_en = (r_state == IDLE) && reset_n;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .i_req       (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .i_en        (w_arb_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    assign w_sel_a = bus.req_a[int'(w_grant_idx) * FP_W +: FP_W];
    assign w_sel_b = bus.req_b[int'(w_grant_idx) * FP_W +: FP_W];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and transition strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_done_hit = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                // The winner is always valid, so a grant is a handshake.
                if (w_grant_vld) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: begin
                w_next = WAIT;
            end
            WAIT: begin
                // done wins over the watchdog when both land together.
                if (bus.mult_done) begin
                    w_done_hit = 1'b1;
                    w_next     = RESP;
                end else if (r_wdog == c_TMO_LAST) begin
                    w_timeout  = 1'b1;
                    w_next     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[r_owner]) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_zero_op  <= 1'b0;
            r_sign     <= 1'b0;
            r_wdog     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a    <= w_sel_a;
                r_op_b    <= w_sel_b;
                r_owner   <= w_grant_idx;
                // Winner drops to lowest priority for the next round.
                r_rr_ptr  <= (w_grant_idx == c_PTR_LAST) ? '0 : w_grant_idx + 1'b1;
                r_zero_op <= fp_is_zero(w_sel_a) || fp_is_zero(w_sel_b);
                r_sign    <= w_sel_a[FP_W-1] ^ w_sel_b[FP_W-1];
            end

            if (r_state == ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == WAIT) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_done_hit) begin
                r_rsp_data <= r_zero_op ? {r_sign, {(FP_W-1){1'b0}}} : bus.mult_product;
                r_rsp_err  <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_data <= FP_QNAN;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_rsp_valid = '0;
        if (r_state == RESP) begin
            w_rsp_valid[r_owner] = 1'b1;
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.mult_start = (r_state == ISSUE);
    assign bus.mult_a     = r_op_a;
    assign bus.mult_b     = r_op_b;
    assign bus.busy       = (r_state != IDLE);

endmodule : fp_mult_scheduler
`default_nettype wire

// File: tb/tb_fp_mult_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mult_scheduler
// Purpose  : Directed self-checking bench for fp_mult_scheduler with a
//            behavioural stub multiplier (programmable latency, hang mode,
//            late-done injection).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mult_scheduler;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fp_mult_scheduler_if #(.N_REQ(N)) bus ();

    fp_mult_scheduler #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- stub multiplier ----------------
    int          stub_lat;
    logic        stub_hang;
    logic        stub_late;
    logic [31:0] stub_prod;
    int          m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.mult_done    <= 1'b0;
            bus.mult_product <= 32'h0;
            m_cnt            <= 0;
        end else if (bus.mult_start) begin
            if (bus.mult_a[30:0] == 31'h0 || bus.mult_b[30:0] == 31'h0) begin
                bus.mult_done <= 1'b1;
            end else begin
                bus.mult_done <= 1'b0;
                m_cnt         <= stub_hang ? 0 : stub_lat;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                bus.mult_done    <= 1'b1;
                bus.mult_product <= stub_prod;
            end
        end else if (stub_late) begin
            bus.mult_done <= 1'b1;
        end
    end

    // ---------------- start pulse monitor ----------------
    int   starts = 0;
    int   dbl_start = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (bus.mult_start === 1'b1) starts++;
        if (bus.mult_start === 1'b1 && prev_start === 1'b1) dbl_start++;
        prev_start = bus.mult_start;
    end

    // ---------------- checking helpers ----------------
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns the cycle index (1 = cycle of the call)
    // in which rsp_valid was first seen, bounded.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (bus.rsp_valid == '0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge in IDLE with no other request pending.
    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b);
        logic [3:0] oh;
        oh = 4'(1 << idx);
        bus.req_valid[idx]      = 1'b1;
        bus.req_a[idx*32 +: 32] = a;
        bus.req_b[idx*32 +: 32] = b;
        #1;
        check("req_ready_winner", 64'(bus.req_ready), 64'(oh));
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        check("issue_start", 64'(bus.mult_start), 64'd1);
        check("issue_mult_a", 64'(bus.mult_a), 64'(a));
        check("issue_mult_b", 64'(bus.mult_b), 64'(b));
    endtask

    task automatic finish_rsp(input int idx);
        bus.rsp_ready[idx] = 1'b1;
        @(negedge clk);
        bus.rsp_ready = '0;
        check("back_to_idle", 64'(bus.busy), 64'd0);
        check("rsp_valid_clr", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    int          cyc;
    int          s0;
    logic [3:0]  exp_oh;
    logic [31:0] a_i;

    initial begin
        bus.req_valid = '1;   // held high in reset: req_ready must stay 0
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        stub_lat  = 3;
        stub_hang = 1'b0;
        stub_late = 1'b0;
        stub_prod = 32'h0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        check("rst_start",     64'(bus.mult_start), 64'd0);
        check("rst_mult_a",    64'(bus.mult_a),    64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        bus.req_valid = '0;
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- 2.0 x 3.0 from requester 0 ----------------
        stub_lat  = 3;
        stub_prod = 32'h40C0_0000;
        s0 = starts;
        send(0, 32'h4000_0000, 32'h4040_0000);
        wait_rsp(cyc);
        check("t1_latency",   64'(cyc), 64'd6);
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("t1_rsp_data",  64'(bus.rsp_data), 64'h40C0_0000);
        check("t1_rsp_err",   64'(bus.rsp_err), 64'd0);
        check("t1_one_start", 64'(starts - s0), 64'd1);
        finish_rsp(0);

        // ---------------- -0.0 x 1.0 from requester 2 ----------------
        send(2, 32'h8000_0000, 32'h3F80_0000);
        wait_rsp(cyc);
        check("t2_latency",   64'(cyc), 64'd3);
        check("t2_rsp_valid", 64'(bus.rsp_valid), 64'h4);
        check("t2_rsp_data",  64'(bus.rsp_data), 64'h8000_0000);
        check("t2_rsp_err",   64'(bus.rsp_err), 64'd0);
        finish_rsp(2);

        // ---------------- owner stalls rsp_ready ----------------
        stub_lat  = 1;
        stub_prod = 32'h4110_0000;
        send(0, 32'h4040_0000, 32'h4040_0000);
        wait_rsp(cyc);
        check("t4_latency",  64'(cyc), 64'd4);
        check("t4_rsp_data", 64'(bus.rsp_data), 64'h4110_0000);
        bus.req_valid[1] = 1'b1;
        bus.rsp_ready    = 4'b0010;   // non-owner ready must be ignored
        s0 = starts;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(bus.rsp_valid), 64'h1);
            check("t4_hold_data",  64'(bus.rsp_data), 64'h4110_0000);
            check("t4_no_accept",  64'(bus.req_ready), 64'd0);
        end
        check("t4_no_start", 64'(starts - s0), 64'd0);
        bus.rsp_ready    = 4'b0001;
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        bus.rsp_ready = '0;
        check("t4_idle", 64'(bus.busy), 64'd0);

        // ---------------- watchdog timeout on requester 1 ----------------
        stub_hang = 1'b1;
        send(1, 32'h3F80_0000, 32'h4000_0000);
        wait_rsp(cyc);
        check("t5_latency",   64'(cyc), 64'(2 + TMO));
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        check("t5_rsp_data",  64'(bus.rsp_data), 64'h7FC0_0000);
        check("t5_rsp_err",   64'(bus.rsp_err), 64'd1);
        finish_rsp(1);
        stub_late = 1'b1;
        @(negedge clk);
        stub_late = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_late_no_rsp",  64'(bus.rsp_valid), 64'd0);
            check("t5_late_no_busy", 64'(bus.busy), 64'd0);
        end

        // ---------------- reset during WAIT ----------------
        send(2, 32'h4000_0000, 32'h4000_0000);
        repeat (3) @(negedge clk);
        check("t6_in_wait", 64'(bus.busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_busy",      64'(bus.busy), 64'd0);
        check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t6_rsp_data",  64'(bus.rsp_data), 64'd0);
        check("t6_rsp_err",   64'(bus.rsp_err), 64'd0);
        check("t6_mult_a",    64'(bus.mult_a), 64'd0);
        check("t6_mult_b",    64'(bus.mult_b), 64'd0);
        check("t6_start",     64'(bus.mult_start), 64'd0);
        @(negedge clk);
        stub_hang = 1'b0;
        reset_n   = 1'b1;

        // ---------------- all requesters, immediate rsp_ready ----------------
        stub_lat  = 2;
        stub_prod = 32'h3F80_0000;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*32 +: 32] = 32'h4000_0000 + 32'(i);
            bus.req_b[i*32 +: 32] = 32'h3F80_0000;
        end
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        for (int g = 0; g < 5; g++) begin
            exp_oh = 4'(1 << (g % N));
            a_i    = 32'h4000_0000 + 32'(g % N);
            #1;
            cyc = 0;
            while (bus.req_ready == '0 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("t3_grant",      64'(bus.req_ready), 64'(exp_oh));
            @(negedge clk);
            check("t3_mult_a",     64'(bus.mult_a), 64'(a_i));
            wait_rsp(cyc);
            check("t3_latency",    64'(cyc), 64'd5);
            check("t3_rsp_valid",  64'(bus.rsp_valid), 64'(exp_oh));
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        repeat (2) @(negedge clk);
        check("t3_final_idle", 64'(bus.busy), 64'd0);
        check("no_double_start", 64'(dbl_start), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_fp_mult_scheduler
`default_nettype wire
